snn_image_loader: RTL and testbench
===================================

Name: snn_image_loader

Overview:
- Sits inside SNN directly downstream of uart_rx. Consumes the 98-byte UART stream carrying one 28x28 binary image (784 pixels) and unpacks it bit-serially into the 784x1 input RAM.
- Pulses img_ready to the classifier core when the full image is stored.
- Holds off further loading until the classifier releases the buffer.

Parameters:
- NUM_BYTES, 98, bytes per image.
- ADDR_W, 10, input RAM address width; must satisfy 2^ADDR_W >= NUM_BYTES*8.
- TIMEOUT_CYC, 2_000_000, inter-byte idle limit in clk cycles. Used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_rdy  in  1  one-cycle strobe from uart_rx: rx_data valid
- rx_data  in  8  received byte
- ram_we  out  1  input RAM write enable
- ram_addr  out  ADDR_W  input RAM write address
- ram_wdata  out  1  pixel bit written
- img_ready  out  1  one-cycle pulse: image complete
- img_release  in  1  classifier finished with buffer; re-arm loader
- overrun  out  1  sticky: byte arrived while loader could not accept it
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0; byte_cnt=0, bit_cnt=0, state=IDLE; shift register cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - rx_rdy -> latch rx_data into shift register, bit_cnt=0, go SHIFT.
  - byte_cnt keeps the count of bytes already stored.
- SHIFT, one pixel per cycle for 8 cycles:
  - ram_we=1, ram_addr=byte_cnt*8+bit_cnt, ram_wdata=shift[0] (LSB first). Shift right.
  - On bit_cnt==7: byte_cnt++.
  - If byte_cnt was NUM_BYTES-1: byte_cnt=0, go DONE. Otherwise go IDLE.
- Write latency: first pixel write occurs the cycle after rx_rdy. A byte occupies exactly 8 consecutive write cycles.
- DONE:
  - img_ready pulses high for exactly the first cycle in DONE.
  - Remain in DONE until img_release=1, then IDLE on the next cycle.
  - img_release in the same cycle as the img_ready pulse is honoured.
- ram_we is 0 in IDLE and DONE. ram_addr and ram_wdata hold their last values when ram_we=0.
- Address arithmetic: byte_cnt*8 is formed as {byte_cnt,3'b000} zero-extended to ADDR_W. The last address written is 783; no wrap within an image.
- Simultaneous events:
  - rx_rdy while in SHIFT or DONE: byte dropped, overrun set.
  - overrun clears only on reset.
  - rx_rdy in the same cycle DONE exits to IDLE: byte dropped (overrun set).
  - img_release outside DONE: ignored.
- Reset mid-image: all counters return to 0. The partially written RAM contents are not cleared; the next image overwrites them fully.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in IDLE while 0 < byte_cnt < NUM_BYTES. It is cleared on every rx_rdy.
  - On reaching TIMEOUT_CYC, byte_cnt resets to 0, discarding the partial image.
  - No img_ready is produced for the discarded image; overrun is unaffected.
- Not defined: no counter exists. A partial image waits indefinitely for further bytes.

Decomposition:
- Package snn_pkg holds:
  - IMG_PIXELS=784, IMG_BYTES=98, PIX_ADDR_W=10;
  - the loader_state_t enum {IDLE, SHIFT, DONE}.
- A sub-module is natural: snn_byte_serializer, an 8-bit load/shift register with bit counter and done flag.
- The FSM and byte counter stay in snn_image_loader.

Test Plan:
- Single byte 0xA5 after reset -> 8 writes at addr 0..7 with data 1,0,1,0,0,1,0,1 on cycles 1..8 after rx_rdy; busy low after the 8th.
- 98 bytes of 0xFF, each spaced 20 cycles -> 784 writes, addresses 0..783 in order, all data 1. img_ready pulses once, 1 cycle after the write to 783. No further writes until img_release.
- rx_rdy 3 cycles after a previous rx_rdy -> second byte dropped, overrun=1, only 8 writes seen. A 3rd byte later is accepted at addr 8..15.
- Full image, then rx_rdy while in DONE -> no write, overrun=1. img_release then new byte 0x01 -> write addr 0 data 1, addr 1..7 data 0.
- rst_n low after 40 bytes, then 98 bytes -> writes start at addr 0 and img_ready occurs after the 98th byte. With LOADER_TIMEOUT_EN and TIMEOUT_CYC=100: 10 bytes, 150 idle cycles, 98 bytes -> the image restarts at addr 0 and img_ready follows the 98th byte after the gap.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the SNN image path.
// Holds image geometry and the loader FSM state type.
package snn_pkg;

    localparam int IMG_PIXELS = 784;
    localparam int IMG_BYTES  = 98;
    localparam int PIX_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } loader_state_t;

endpackage

// File: rtl/snn_byte_serializer.sv
// 8-bit load/shift register emitting one bit per shift, LSB first.
// Ports: clk, rst_n, load+data (capture byte), shift_en (advance),
//        pixel (current LSB), bit_cnt (bits already shifted), last (bit 7).
module snn_byte_serializer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       shift_en,
    output logic       pixel,
    output logic [2:0] bit_cnt,
    output logic       last
);

    logic [7:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= data;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign pixel = shreg[0];
    assign last  = (bit_cnt == 3'd7);

endmodule

// File: rtl/snn_image_loader.sv
// Unpacks a UART byte stream into the bit-wide input RAM, one pixel
// per cycle, and signals the classifier when a full image is stored.
// Ports: clk, rst_n, rx_rdy/rx_data (UART byte), ram_we/ram_addr/
//        ram_wdata (RAM write), img_ready (pulse), img_release (re-arm),
//        overrun (sticky drop flag), busy (not IDLE).
// Optional: define LOADER_TIMEOUT_EN to discard a partial image after
//           TIMEOUT_CYC idle cycles between bytes.
module snn_image_loader
    import snn_pkg::*;
#(
    parameter int NUM_BYTES   = IMG_BYTES,
    parameter int ADDR_W      = PIX_ADDR_W,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    output logic              img_ready,
    input  logic              img_release,
    output logic              overrun,
    output logic              busy
);

    localparam int BC_W = ADDR_W - 3;

    if (((1 << ADDR_W) < NUM_BYTES * 8) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
        $error("snn_image_loader: invalid ADDR_W/NUM_BYTES/TIMEOUT_CYC");
    end

    loader_state_t state, state_nx;

    logic [BC_W-1:0]   byte_cnt;
    logic              last_byte;
    logic              ser_load;
    logic              ser_shift;
    logic              ser_pixel;
    logic [2:0]        ser_bit;
    logic              ser_last;
    logic [ADDR_W-1:0] addr_q;
    logic              wdata_q;
    logic              tmo;

    snn_byte_serializer u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load),
        .data     (rx_data),
        .shift_en (ser_shift),
        .pixel    (ser_pixel),
        .bit_cnt  (ser_bit),
        .last     (ser_last)
    );

    assign last_byte = (byte_cnt == BC_W'(NUM_BYTES - 1));

    always_comb begin
        state_nx  = state;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_rdy) begin
                    ser_load = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                ser_shift = 1'b1;
                if (ser_last) begin
                    state_nx = last_byte ? DONE : IDLE;
                end
            end
            DONE: begin
                if (img_release) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address and data are live only while writing; otherwise the last
    // written values are held so the RAM port stays quiet.
    assign ram_we    = (state == SHIFT);
    assign ram_addr  = ram_we ? {byte_cnt, ser_bit} : addr_q;
    assign ram_wdata = ram_we ? ser_pixel : wdata_q;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            addr_q    <= '0;
            wdata_q   <= 1'b0;
            img_ready <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            img_ready <= (state == SHIFT) && ser_last && last_byte;
            if (rx_rdy && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (ram_we) begin
                addr_q  <= ram_addr;
                wdata_q <= ram_wdata;
            end
            if ((state == SHIFT) && ser_last) begin
                byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
            end else if (tmo) begin
                byte_cnt <= '0;
            end
        end
    end

`ifdef LOADER_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT_CYC + 1);

    logic [TC_W-1:0] idle_cnt;
    logic            idle_run;

    // Counts only while a partial image sits waiting for its next byte.
    assign idle_run = (state == IDLE) && (byte_cnt != '0) && !rx_rdy;
    assign tmo      = idle_run && (idle_cnt == TC_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (idle_run && !tmo) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_snn_image_loader.sv
// Self-checking bench for snn_image_loader: vector table for one byte,
// directed corner sequences and randomized streams vs. a queue model.
module tb_snn_image_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       img_release = 1'b0;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_wdata;
    logic       img_ready;
    logic       overrun;
    logic       busy;

    snn_image_loader #(
        .NUM_BYTES   (98),
        .ADDR_W      (10),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .img_ready   (img_ready),
        .img_release (img_release),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [9:0] addr;
        logic       d;
    } wr_t;

    wr_t wr_q[$];
    wr_t exp_q[$];
    int  rdy_q[$];
    int  exp_rdy[$];

    always @(negedge clk) begin
        if (ram_we === 1'b1) wr_q.push_back({ram_addr, ram_wdata});
        if (img_ready === 1'b1) rdy_q.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference model: a byte is taken if the loader is not holding a
    // finished image and at least 9 edges passed since the last taken
    // byte (8 write cycles plus the return to idle).
    int stored   = 0;
    int last_acc = -100;
    bit in_done  = 0;
    bit exp_ovr  = 0;

    task automatic model_reset();
        stored   = 0;
        last_acc = -100;
        in_done  = 0;
        exp_ovr  = 0;
        wr_q.delete();
        exp_q.delete();
        rdy_q.delete();
        exp_rdy.delete();
    endtask

    task automatic send(input logic [7:0] v, output int samp);
        @(posedge clk);
        #1;
        rx_rdy  = 1'b1;
        rx_data = v;
        samp    = cyc + 1;
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        if (!in_done && (samp - last_acc >= 9)) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back(wr_t'{addr: 10'(stored * 8 + i), d: v[i]});
            end
            stored++;
            last_acc = samp;
            if (stored == 98) begin
                stored  = 0;
                in_done = 1;
                exp_rdy.push_back(samp + 8);
            end
        end else begin
            exp_ovr = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_buf();
        @(posedge clk);
        #1;
        img_release = 1'b1;
        @(posedge clk);
        #1;
        img_release = 1'b0;
        in_done = 0;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_log(input string name);
        int bad;
        int n;
        repeat (12) @(posedge clk);
        #1;
        chk({name, " nwrites"}, wr_q.size(), exp_q.size());
        n   = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        bad = -1;
        for (int i = 0; i < n; i++) begin
            if (wr_q[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s write#%0d got addr %0d d %0d want addr %0d d %0d",
                     name, bad, wr_q[bad].addr, wr_q[bad].d,
                     exp_q[bad].addr, exp_q[bad].d);
        end
        chk({name, " nready"}, rdy_q.size(), exp_rdy.size());
        for (int i = 0; i < rdy_q.size() && i < exp_rdy.size(); i++) begin
            chk({name, " ready_cyc"}, rdy_q[i], exp_rdy[i]);
        end
        chk({name, " overrun"}, overrun, exp_ovr);
        wr_q.delete();
        exp_q.delete();
        rdy_q.delete();
        exp_rdy.delete();
    endtask

    typedef struct {
        logic       we;
        logic [9:0] addr;
        logic       d;
        logic       bsy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [7:0] v;

        // byte 0xA5: LSB-first pixels, then idle with held addr/data
        tbl[0] = '{1'b1, 10'd0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 10'd1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 10'd2, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 10'd3, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 10'd4, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 10'd5, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 10'd6, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 10'd7, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 10'd7, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ram_we", ram_we, 0);
        chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_wdata", ram_wdata, 0);
        chk("rst img_ready", img_ready, 0);
        chk("rst overrun", overrun, 0);
        chk("rst busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        send(8'hA5, s);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("a5 vec%0d", i),
                {ram_we, ram_addr, ram_wdata, busy},
                {tbl[i].we, tbl[i].addr, tbl[i].d, tbl[i].bsy});
        end
        check_log("a5");

        // second byte 3 cycles after the first is dropped
        do_reset();
        send(8'($urandom), s);
        idle(1);
        send(8'($urandom), s);
        idle(1);
        release_buf();
        idle(12);
        send(8'($urandom), s);
        check_log("overrun");

        // full image of 0xFF, spaced 20 cycles
        do_reset();
        for (int b = 0; b < 98; b++) begin
            send(8'hFF, s);
            idle(18);
        end
        idle(30);
        chk("done busy", busy, 1);
        check_log("ff_image");
        send(8'h3C, s);
        idle(4);
        chk("done drop overrun", overrun, 1);
        release_buf();
        send(8'h01, s);
        check_log("after_release");

        // reset mid-image, then a random image; release during pulse
        do_reset();
        for (int b = 0; b < 40; b++) begin
            send(8'($urandom), s);
            idle(9);
        end
        check_log("partial40");
        do_reset();
        for (int b = 0; b < 98; b++) begin
            send(8'($urandom), s);
            idle($urandom_range(7, 12));
        end
        idle(3);
        chk("rnd img busy", busy, 1);
        send(8'h81, s);
        // s is now a dropped byte; wait for the ready of the image
        wait_ready: begin
            int t0;
            t0 = exp_rdy[0];
            while (cyc < t0) begin
                @(posedge clk);
                #1;
            end
        end
        release_buf();
        send(8'($urandom), s);
        check_log("rnd_image");

        // random spacing, some bytes land during a shift
        do_reset();
        for (int b = 0; b < 40; b++) begin
            v = 8'($urandom);
            send(v, s);
            idle($urandom_range(0, 10));
        end
        check_log("rnd_spacing");

`ifdef LOADER_TIMEOUT_EN
        do_reset();
        for (int b = 0; b < 10; b++) begin
            send(8'($urandom), s);
            idle(9);
        end
        idle(150);
        stored = 0;
        for (int b = 0; b < 98; b++) begin
            send(8'($urandom), s);
            idle(9);
        end
        check_log("timeout");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
